weight_init_seq: RTL and testbench

Weight initialisation sequencer that sits directly upstream of the weight RAM. On a start request it fills all RAM locations with pseudo-random signed weights drawn from a 16-bit LFSR. It then reads every location back, compares each word against the regenerated sequence, and reports a mismatch count. It owns the RAM's D/Address/WE port during a run and releases it (WE=0) when idle.

---
 rtl/weight_init_seq.sv | 139 +++++++++++++
 tb/tb_weight_init_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/weight_init_seq.sv
// Weight RAM initialisation sequencer: fills the RAM from a 16-bit Galois LFSR,
// reads it back against the regenerated sequence and counts mismatches.
module weight_init_seq #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7,
    parameter int unsigned DW    = 10,
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int unsigned SHIFT = 2
) (
    input  logic          Clock,
    input  logic          Rst,
    input  logic          Start,
    input  logic          SeedLoad,
    input  logic [15:0]   Seed,
    input  logic [DW-1:0] Q,
    output logic          WE,
    output logic [AW-1:0] Address,
    output logic [DW-1:0] D,
    output logic          Busy,
    output logic          Done,
    output logic [7:0]    Errors,
    output logic          ErrFlag
);

    localparam logic [15:0]   TAPS = 16'hB400;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FIN} state_t;

    state_t        state, state_n;
    logic [15:0]   seed_q, seed_n;
    logic [15:0]   lfsr, lfsr_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] d_n;
    logic [DW-1:0] exp_q, exp_n;
    logic [DW-1:0] exp_d;
    logic          cmp_en, cmp_en_n;
    logic [7:0]    err_n;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? TAPS : 16'h0000);
    endfunction

    function automatic logic [DW-1:0] weight(input logic [15:0] s);
        logic signed [DW-1:0] raw;
        raw = $signed(s[DW-1:0]);
        return raw >>> SHIFT;
    endfunction

    // Next-state, datapath and mismatch accounting
    always_comb begin
        state_n  = state;
        seed_n   = seed_q;
        lfsr_n   = lfsr;
        addr_n   = Address;
        d_n      = D;
        exp_n    = exp_q;
        err_n    = Errors;
        cmp_en_n = (state == READ);

        case (state)
            IDLE: begin
                addr_n = '0;
                if (SeedLoad) begin
                    seed_n = (Seed == 16'h0000) ? SEED : Seed;
                end
                if (Start) begin
                    state_n = WRITE;
                    d_n     = weight(seed_n);
                    lfsr_n  = lfsr_step(seed_n);
                    err_n   = 8'd0;
                end
            end
            WRITE: begin
                if (Address == LAST) begin
                    state_n = READ;
                    addr_n  = '0;
                    exp_n   = weight(seed_q);
                    lfsr_n  = lfsr_step(seed_q);
                end else begin
                    addr_n = AW'(Address + 1'b1);
                    d_n    = weight(lfsr);
                    lfsr_n = lfsr_step(lfsr);
                end
            end
            READ: begin
                if (Address == LAST) begin
                    state_n = DRAIN;
                    addr_n  = '0;
                end else begin
                    addr_n = AW'(Address + 1'b1);
                    exp_n  = weight(lfsr);
                    lfsr_n = lfsr_step(lfsr);
                end
            end
            DRAIN:   state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Q carries the word addressed one cycle earlier
        if (cmp_en && (Q != exp_d) && (Errors != 8'hFF)) begin
            err_n = Errors + 8'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Rst) begin
            state   <= IDLE;
            seed_q  <= SEED;
            lfsr    <= SEED;
            exp_q   <= '0;
            exp_d   <= '0;
            cmp_en  <= 1'b0;
            WE      <= 1'b0;
            Address <= '0;
            D       <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Errors  <= 8'd0;
            ErrFlag <= 1'b0;
        end else begin
            state   <= state_n;
            seed_q  <= seed_n;
            lfsr    <= lfsr_n;
            exp_q   <= exp_n;
            exp_d   <= exp_q;
            cmp_en  <= cmp_en_n;
            WE      <= (state_n == WRITE);
            Address <= addr_n;
            D       <= d_n;
            Busy    <= (state_n == WRITE) || (state_n == READ) || (state_n == DRAIN);
            Done    <= (state_n == FIN);
            Errors  <= err_n;
            ErrFlag <= (err_n != 8'd0);
        end
    end

endmodule

// File: tb/tb_weight_init_seq.sv
// Bench for weight_init_seq: 1-cycle RAM model with read-fault injection and a
// behavioural weight-sequence model.
module tb_weight_init_seq;

    localparam int DEPTH  = 128;
    localparam int AW     = 7;
    localparam int DW     = 10;
    localparam int DEPTH2 = 512;
    localparam int AW2    = 9;
    localparam int RUNLEN = 2 * DEPTH + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          start = 1'b0, seed_load = 1'b0;
    logic [15:0]   seed = 16'h0;
    logic [DW-1:0] q = '0;
    logic          we, busy, done, err_flag;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    logic [7:0]    errors;

    logic           start2 = 1'b0, seed_load2 = 1'b0;
    logic [15:0]    seed2 = 16'h0;
    logic [DW-1:0]  q2 = '0;
    logic           we2, busy2, done2, err_flag2;
    logic [AW2-1:0] addr2;
    logic [DW-1:0]  d2;
    logic [7:0]     errors2;

    weight_init_seq u_dut (
        .Clock(clk), .Rst(rst_n), .Start(start), .SeedLoad(seed_load), .Seed(seed),
        .Q(q), .WE(we), .Address(addr), .D(d), .Busy(busy), .Done(done),
        .Errors(errors), .ErrFlag(err_flag)
    );

    weight_init_seq #(.DEPTH(DEPTH2), .AW(AW2)) u_big (
        .Clock(clk), .Rst(rst_n), .Start(start2), .SeedLoad(seed_load2), .Seed(seed2),
        .Q(q2), .WE(we2), .Address(addr2), .D(d2), .Busy(busy2), .Done(done2),
        .Errors(errors2), .ErrFlag(err_flag2)
    );

    // RAM models; reads can be corrupted by flipping bit 3
    logic [DW-1:0] mem  [DEPTH];
    logic          flip [DEPTH];
    logic [DW-1:0] mem2 [DEPTH2];

    always @(posedge clk) begin
        if (we) mem[addr] <= d;
        q <= mem[addr] ^ (flip[addr] ? DW'(8) : DW'(0));
        if (we2) mem2[addr2] <= d2;
        q2 <= mem2[addr2] ^ DW'(8);
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    int            wexp [DEPTH];
    logic [15:0]   mseed = 16'hACE1;
    logic [DW-1:0] d_first, d_second;

    typedef struct {
        logic        sl;
        logic [15:0] sd;
        int          fault;
        bit          poke;
        int          d0;
        int          d1;
        int          err;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] to_w(input int v);
        return DW'(v);
    endfunction

    // Weight k = floor(signed low DW bits of LFSR state k / 4)
    task automatic build_model(input logic [15:0] s0);
        int unsigned s;
        int v;
        s = 32'(s0);
        for (int k = 0; k < DEPTH; k++) begin
            v = int'(s % 1024);
            if (v >= 512) v = v - 1024;
            wexp[k] = (v >= 0) ? v / 4 : -((3 - v) / 4);
            s = (s % 2 == 1) ? ((s / 2) ^ 32'hB400) : s / 2;
        end
    endtask

    task automatic set_faults(input int mode, output int cnt);
        cnt = 0;
        for (int k = 0; k < DEPTH; k++) begin
            case (mode)
                1:       flip[k] = (k == 5) || (k == DEPTH - 1);
                2:       flip[k] = 1'b1;
                3:       flip[k] = ($urandom_range(15) == 0);
                default: flip[k] = 1'b0;
            endcase
            if (flip[k]) cnt++;
        end
        if (cnt > 255) cnt = 255;
    endtask

    // One full run from IDLE, checked every cycle; called right after a negedge
    task automatic run_check(input string tag, input logic sl, input logic [15:0] sd,
                             input bit poke, input int exp_err);
        logic [19:0] act, exp;
        if (sl) mseed = (sd == 16'h0) ? 16'hACE1 : sd;
        build_model(mseed);
        seed_load = sl;
        seed      = sd;
        start     = 1'b1;
        for (int c = 1; c <= RUNLEN; c++) begin
            @(negedge clk);
            start     = 1'b0;
            seed_load = 1'b0;
            if (poke && (c == 40 || c == 170)) begin
                start     = 1'b1;
                seed_load = 1'b1;
                seed      = 16'($urandom);
            end
            if (c == 1) d_first = d;
            if (c == 2) d_second = d;
            if (c <= DEPTH) begin
                act = {we, addr, d, busy, done};
                exp = {1'b1, AW'(c - 1), to_w(wexp[c - 1]), 1'b1, 1'b0};
            end else if (c <= 2 * DEPTH) begin
                act = {we, addr, d, busy, done};
                exp = {1'b0, AW'(c - DEPTH - 1), to_w(wexp[DEPTH - 1]), 1'b1, 1'b0};
            end else begin
                act = {7'd0, we, d, busy, done};
                exp = {7'd0, 1'b0, to_w(wexp[DEPTH - 1]), c == 2 * DEPTH + 1, c == RUNLEN};
            end
            check($sformatf("%s cyc%0d", tag, c), 64'(act), 64'(exp));
            if (c == 1) check($sformatf("%s err_clear", tag), 64'(errors), 64'd0);
            if (c == RUNLEN) begin
                check($sformatf("%s errors", tag), 64'(errors), 64'(exp_err));
                check($sformatf("%s errflag", tag), 64'(err_flag), 64'(exp_err != 0));
            end
        end
        @(negedge clk);
        check($sformatf("%s idle", tag), 64'({we, addr, busy, done, errors}),
              64'({1'b0, AW'(0), 1'b0, 1'b0, 8'(exp_err)}));
    endtask

    initial begin
        int cnt;
        int dones;
        int busies;

        tbl[0] = '{1'b0, 16'h0000, 0, 1'b0,  56, -100,   0};
        tbl[1] = '{1'b0, 16'h0000, 1, 1'b0,  56, -100,   2};
        tbl[2] = '{1'b0, 16'h0000, 2, 1'b0,  56, -100, 128};
        tbl[3] = '{1'b1, 16'h0001, 0, 1'b0,   0,    0,   0};
        tbl[4] = '{1'b1, 16'h0000, 0, 1'b0,  56, -100,   0};
        tbl[5] = '{1'b0, 16'h0000, 0, 1'b1,  56, -100,   0};
        for (int k = 0; k < DEPTH; k++) flip[k] = 1'b0;

        // Reset and idle hold
        repeat (3) @(negedge clk);
        check("reset", 64'({we, addr, d, busy, done, errors, err_flag}), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d", i), 64'({we, addr, d, busy, done, errors, err_flag}), 64'd0);
        end

        // Directed table
        for (int i = 0; i < 6; i++) begin
            set_faults(tbl[i].fault, cnt);
            check($sformatf("row%0d fault_count", i), 64'(cnt), 64'(tbl[i].err));
            run_check($sformatf("row%0d", i), tbl[i].sl, tbl[i].sd, tbl[i].poke, tbl[i].err);
            check($sformatf("row%0d d0", i), 64'(d_first), 64'(to_w(tbl[i].d0)));
            check($sformatf("row%0d d1", i), 64'(d_second), 64'(to_w(tbl[i].d1)));
        end

        // Randomized runs against the model
        for (int r = 0; r < 4; r++) begin
            logic [15:0] rs;
            rs = (r == 2) ? 16'h0 : 16'($urandom);
            set_faults(3, cnt);
            run_check($sformatf("rand%0d", r), r != 1, rs, bit'($urandom_range(1)), cnt);
        end

        // Reset in mid-WRITE aborts the run and restores the default seed
        set_faults(0, cnt);
        seed_load = 1'b1;
        seed      = 16'h1234;
        start     = 1'b1;
        for (int c = 1; c < 60; c++) begin
            @(negedge clk);
            start     = 1'b0;
            seed_load = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort outputs", 64'({we, addr, d, busy, done, errors, err_flag}), 64'd0);
        rst_n  = 1'b1;
        dones  = 0;
        busies = 0;
        for (int c = 0; c < RUNLEN + 10; c++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busies++;
        end
        check("abort no_done", 64'(dones), 64'd0);
        check("abort no_busy", 64'(busies), 64'd0);
        mseed = 16'hACE1;
        run_check("after_abort", 1'b0, 16'h0, 1'b0, 0);
        check("after_abort d0", 64'(d_first), 64'(to_w(56)));

        // Saturation on the deep instance: every read is corrupted
        start2 = 1'b1;
        for (int c = 1; c <= 2 * DEPTH2 + 2; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (c == 2 * DEPTH2 + 1)
                check("big drain", 64'({busy2, done2}), 64'({1'b1, 1'b0}));
        end
        check("big done", 64'({busy2, done2}), 64'({1'b0, 1'b1}));
        check("big errors", 64'(errors2), 64'd255);
        check("big errflag", 64'(err_flag2), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
